// File: rtl/knn_local_buf_port_master.sv
// Initiator for the single-port local buffer (address0/ce0/we0/d0/q0).
// Fills the buffer from a valid/ready stream or drains it to one. Read
// latency is hidden behind a credit-controlled output FIFO.
// Optional macro KNN_LOCAL_BUF_PERF_CNT_EN adds the stall_cycles counter.
module knn_local_buf_port_master #(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_start,
  input  logic                  cmd_mode,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_count,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] address0,
  output logic                  ce0,
  output logic                  we0,
  output logic [DATA_WIDTH-1:0] d0,
  input  logic [DATA_WIDTH-1:0] q0
`ifdef KNN_LOCAL_BUF_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W   = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic                    ce0_q, ce0_d, we0_q, we0_d;
  logic [ADDR_WIDTH-1:0]   address0_q, address0_d;
  logic [DATA_WIDTH-1:0]   d0_q, d0_d;
  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;

  logic            cmd_accept, s_fire, m_fire, rd_pending, push, rd_issue;
  logic [CR_W-1:0] inflight, credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cmd_accept = (state_q == S_IDLE) && cmd_start && !busy_q;
  assign s_ready    = (state_q == S_FILL) && (remaining_q != '0);
  assign s_fire     = s_ready && s_valid;
  assign m_valid    = (fifo_cnt_q != '0);
  assign m_fire     = m_valid && m_ready;
  assign m_data     = m_valid ? fifo_mem_q[rd_ptr_q] : '0;
  // A read presented on the port this cycle is already committed to a FIFO slot.
  assign rd_pending = ce0_q && !we0_q;
  assign push       = rd_vld_q[READ_LATENCY-1];
  assign busy       = busy_q;
  assign done       = done_q;
  assign ce0        = ce0_q;
  assign we0        = we0_q;
  assign address0   = address0_q;
  assign d0         = d0_q;

  // Count reads between issue and FIFO capture; a slot popped this cycle counts as free.
  always_comb begin
    inflight = CR_W'(rd_pending);
    for (int k = 0; k < READ_LATENCY; k++) inflight = inflight + CR_W'(rd_vld_q[k]);
    credit_used = CR_W'(fifo_cnt_q) + inflight - CR_W'(m_fire);
    rd_issue    = (state_q == S_DRAIN) && (remaining_q != '0) &&
                  (credit_used < CR_W'(FIFO_DEPTH));
  end

  // Command FSM next state and registered memory-port values.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = (state_q == S_DONE);
    addr_d      = addr_q;
    remaining_d = remaining_q;
    ce0_d       = 1'b0;
    we0_d       = 1'b0;
    address0_d  = address0_q;
    d0_d        = d0_q;
    if (done_q) busy_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          busy_d      = 1'b1;
          addr_d      = cmd_base;
          remaining_d = cmd_count;
          if (cmd_count == '0) state_d = S_DONE;
          else if (cmd_mode)   state_d = S_DRAIN;
          else                 state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (s_fire) begin
          ce0_d       = 1'b1;
          we0_d       = 1'b1;
          d0_d        = s_data;
          address0_d  = addr_q;
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (rd_issue) begin
          ce0_d       = 1'b1;
          address0_d  = addr_q;
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if ((inflight == '0) && (fifo_cnt_q == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read-valid shift register and output FIFO bookkeeping.
  always_comb begin
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q + FCNT_W'(push) - FCNT_W'(m_fire);
    rd_vld_d    = rd_vld_q << 1;
    rd_vld_d[0] = rd_pending;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = q0;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (m_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // Control and port registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      ce0_q       <= 1'b0;
      we0_q       <= 1'b0;
      address0_q  <= '0;
      d0_q        <= '0;
      rd_vld_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      ce0_q       <= ce0_d;
      we0_q       <= we0_d;
      address0_q  <= address0_d;
      d0_q        <= d0_d;
      rd_vld_q    <= rd_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // FIFO storage holds data only; the count and pointers decide validity.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

`ifdef KNN_LOCAL_BUF_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_cond;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign stall_cond = ((state_q == S_FILL) && !s_valid) ||
                      (((state_q == S_DRAIN) || (state_q == S_FLUSH)) && m_valid && !m_ready);
  assign stall_cycles = stall_q;

  // Stall counter, restarted by each accepted command.
  always_comb begin
    stall_d = stall_q;
    if (cmd_accept)                stall_d = '0;
    else if (busy_q && stall_cond) stall_d = sat_inc(stall_q);
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end
`endif

endmodule

// File: tb/tb_knn_local_buf_port_master.sv
// Directed bench with a behavioural 2-cycle-latency RAM and a scoreboard of
// expected writes, read addresses and drain beats.
module tb_knn_local_buf_port_master;
  localparam int DW = 256;
  localparam int AW = 11;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, cmd_start, cmd_mode, busy, done;
  logic [AW-1:0] cmd_base, address0;
  logic [AW:0]   cmd_count;
  logic [DW-1:0] s_data, m_data, d0, q0, r1;
  logic          s_valid, s_ready, m_valid, m_ready, ce0, we0;
`ifdef KNN_LOCAL_BUF_PERF_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  knn_local_buf_port_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_mode(cmd_mode),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .address0(address0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0)
`ifdef KNN_LOCAL_BUF_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // Behavioural single-port RAM, read latency 2 from ce0.
  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (ce0 && we0) mem[address0] <= d0;
    if (ce0 && !we0) r1 <= mem[address0];
    q0 <= r1;
  end

  logic [DW-1:0] model [0:2047];
  logic [DW-1:0] rexp[$];
  logic [DW-1:0] wdata_exp[$];
  logic [AW-1:0] waddr_exp[$];
  logic [AW-1:0] raddr_exp[$];
  logic [AW-1:0] fill_addr;
  int checks = 0, failures = 0;
  int done_cnt, ce_cnt, rd_issued, beats, cyc_n = 0;
  int first_w, last_w, first_b, last_b;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic sf, mf, stall_now;
    logic [DW-1:0] hold, e;
    logic [AW-1:0] a;
    sf = s_valid && s_ready;
    mf = m_valid && m_ready;
    stall_now = m_valid && !m_ready && reset_n;
    hold = m_data;
    if (sf) begin
      waddr_exp.push_back(fill_addr);
      wdata_exp.push_back(s_data);
      model[fill_addr] = s_data;
      fill_addr = fill_addr + 1'b1;
    end
    if (mf) begin
      beats++;
      if (first_b < 0) first_b = cyc_n;
      last_b = cyc_n;
      if (rexp.size() == 0) check("unexpected_beat", DW'(1), DW'(0));
      else begin e = rexp.pop_front(); check("m_data", m_data, e); end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (stall_now) begin
      check("m_valid_hold", DW'(m_valid), DW'(1));
      check("m_data_hold", m_data, hold);
    end
    if (ce0) ce_cnt++;
    if (ce0 && we0) begin
      if (first_w < 0) first_w = cyc_n;
      last_w = cyc_n;
      if (waddr_exp.size() == 0) check("unexpected_write", DW'(1), DW'(0));
      else begin
        a = waddr_exp.pop_front(); e = wdata_exp.pop_front();
        check("wr_addr", DW'(address0), DW'(a));
        check("wr_data", d0, e);
      end
    end
    if (ce0 && !we0) begin
      rd_issued++;
      if (raddr_exp.size() == 0) check("unexpected_read", DW'(1), DW'(0));
      else begin a = raddr_exp.pop_front(); check("rd_addr", DW'(address0), DW'(a)); end
      check("outstanding_le_depth", DW'((rd_issued - beats) <= FD), DW'(1));
    end
    if (done) done_cnt++;
  endtask

  task automatic start_cmd(input logic mode, input int base, input int count);
    logic [AW-1:0] a;
    cmd_start = 1'b1; cmd_mode = mode;
    cmd_base = AW'(base); cmd_count = (AW+1)'(count);
    done_cnt = 0; ce_cnt = 0; rd_issued = 0; beats = 0;
    first_w = -1; last_w = -1; first_b = -1; last_b = -1;
    if (mode) begin
      for (int i = 0; i < count; i++) begin
        a = AW'(base + i);
        raddr_exp.push_back(a);
        rexp.push_back(model[a]);
      end
    end else fill_addr = AW'(base);
    cyc();
    cmd_start = 1'b0;
  endtask

  task automatic do_fill(input int base, input int count, input int data0, input int stall_first);
    int idx, n;
    idx = 0; n = 0;
    start_cmd(1'b0, base, count);
    while (done_cnt == 0 && n < 300) begin
      s_valid = (n >= stall_first) && (idx < count);
      s_data  = {8{32'(data0 + idx)}};
      if (s_valid && s_ready) idx++;
      cyc(); n++;
    end
    s_valid = 1'b0;
`ifdef KNN_LOCAL_BUF_PERF_CNT_EN
    check("stall_cycles_at_done", DW'(stall_cycles), DW'(stall_first));
`endif
    cyc(); cyc();
    check("fill_done_once", DW'(done_cnt), DW'(1));
    check("fill_writes_drained", DW'(waddr_exp.size()), DW'(0));
    if (stall_first == 0) check("fill_back_to_back", DW'(last_w - first_w), DW'(count - 1));
  endtask

  task automatic do_drain(input int base, input int count, input logic toggle);
    int n;
    n = 0;
    start_cmd(1'b1, base, count);
    check("s_ready_low_in_drain", DW'(s_ready), DW'(0));
    while (done_cnt == 0 && n < 400) begin
      m_ready = toggle ? (((n / 2) % 2) == 0) : 1'b1;
      cyc(); n++;
    end
    m_ready = 1'b0;
    cyc(); cyc();
    check("drain_done_once", DW'(done_cnt), DW'(1));
    check("drain_beats", DW'(beats), DW'(count));
    check("drain_reads_all_issued", DW'(raddr_exp.size()), DW'(0));
    check("drain_no_leftover", DW'(rexp.size()), DW'(0));
    if (!toggle) check("drain_back_to_back", DW'(last_b - first_b), DW'(count - 1));
  endtask

  initial begin
    reset_n = 1'b0; cmd_start = 1'b0; cmd_mode = 1'b0; cmd_base = '0; cmd_count = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0; fill_addr = '0;
    done_cnt = 0; ce_cnt = 0; rd_issued = 0; beats = 0;
    first_w = -1; last_w = -1; first_b = -1; last_b = -1;
    cyc(); cyc();
    check("rst_ctrl", DW'({busy, done, s_ready, m_valid, ce0, we0}), DW'(0));
    check("rst_addr", DW'(address0), DW'(0));
    check("rst_d0", d0, DW'(0));
    reset_n = 1'b1;
    cyc();
    check("idle_busy", DW'(busy), DW'(0));

    // Fill then drain, base 0, count 4.
    do_fill(0, 4, 'hA0, 0);
    do_drain(0, 4, 1'b0);

    // Wrap-around at the top of the buffer.
    do_fill(2046, 4, 'hB0, 0);
    do_drain(2046, 4, 1'b0);

    // Backpressure with m_ready toggling every 2 cycles.
    do_fill(100, 16, 'hC00, 0);
    do_drain(100, 16, 1'b1);

    // count=0 in both modes, plus cmd_start while busy and on the done cycle.
    start_cmd(1'b0, 0, 0);
    check("cnt0_busy", DW'(busy), DW'(1));
    check("cnt0_no_early_done", DW'(done), DW'(0));
    cmd_start = 1'b1; cmd_mode = 1'b1; cmd_count = (AW+1)'(5);
    cyc();
    check("cnt0_done_at_2", DW'(done), DW'(1));
    cyc();
    cmd_start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    check("cnt0_single_done", DW'(done_cnt), DW'(1));
    check("cnt0_no_ce0", DW'(ce_cnt), DW'(0));
    check("cnt0_idle", DW'(busy), DW'(0));
    start_cmd(1'b1, 0, 0);
    cyc();
    check("cnt0_drain_done_at_2", DW'(done), DW'(1));
    cyc(); cyc();
    check("cnt0_drain_no_ce0", DW'(ce_cnt), DW'(0));

    // Reset in the middle of a drain of 8.
    m_ready = 1'b0;
    start_cmd(1'b1, 0, 8);
    for (int i = 0; i < 4; i++) cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    check("midrst_ctrl", DW'({busy, done, s_ready, m_valid, ce0, we0}), DW'(0));
    check("midrst_addr", DW'(address0), DW'(0));
    check("midrst_m_data", m_data, DW'(0));
    rexp.delete(); raddr_exp.delete();
    for (int i = 0; i < 6; i++) cyc();
    check("midrst_no_done", DW'(done_cnt), DW'(0));
    check("midrst_no_activity", DW'({busy, m_valid, ce0}), DW'(0));
    do_fill(5, 1, 'hD5, 0);
    do_drain(5, 1, 1'b0);

`ifdef KNN_LOCAL_BUF_PERF_CNT_EN
    do_fill(200, 4, 'hE0, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/knn_local_buf_port_master.md
Name: knn_local_buf_port_master

Overview:
- Initiator side of the single-port local-buffer memory interface (address0/ce0/we0/d0/q0) used by the partialKnn wrappers.
- Fills a 256-bit x 2048 local buffer from a valid/ready input stream, or drains it to a valid/ready output stream.
- Hides the memory read latency behind a credit-controlled output FIFO, so downstream backpressure never loses read data.
- Sits between the kernel's load/compute stages and each local_SP buffer instance.

Parameters:
- DATA_WIDTH, 256, word width on memory and streams.
- ADDR_WIDTH, 11, memory address width; buffer depth is 2**ADDR_WIDTH.
- READ_LATENCY, 2, cycles from ce0 (we0=0) to valid q0; must be >= 1.
- FIFO_DEPTH, 4, drain output FIFO entries; must be >= READ_LATENCY+2.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-low
- cmd_start  in  1  one-cycle command strobe
- cmd_mode  in  1  0 = fill, 1 = drain
- cmd_base  in  ADDR_WIDTH  first address
- cmd_count  in  ADDR_WIDTH+1  words to transfer, 0..2**ADDR_WIDTH
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- s_data  in  DATA_WIDTH  fill stream data
- s_valid  in  1  fill stream valid
- s_ready  out  1  fill stream ready
- m_data  out  DATA_WIDTH  drain stream data
- m_valid  out  1  drain stream valid
- m_ready  in  1  drain stream ready
- address0  out  ADDR_WIDTH  memory address
- ce0  out  1  memory enable
- we0  out  1  memory write enable
- d0  out  DATA_WIDTH  memory write data
- q0  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0, FSM to IDLE, FIFO emptied, in-flight reads discarded. Reset mid-command aborts it with no done pulse.
- All memory-side outputs are registered.
- States: IDLE, FILL, DRAIN, FLUSH, DONE.
- IDLE:
  - cmd_start latches base and count, sets busy=1.
  - count=0 goes to DONE.
  - Otherwise goes to FILL (mode 0) or DRAIN (mode 1).
  - cmd_start while busy=1 is ignored.
- FILL:
  - s_ready=1 while remaining>0.
  - A handshake at cycle t drives ce0=1, we0=1, d0=s_data, address0=base+i at cycle t+1; otherwise ce0=we0=0.
  - Last handshake goes to DONE; done is asserted the cycle after the final write is presented.
- DRAIN:
  - A read is issued (ce0=1, we0=0, address0=base+i) only when fifo_count + inflight < FIFO_DEPTH and issued < count.
  - q0 is captured into the FIFO exactly READ_LATENCY cycles after issue, tracked by a READ_LATENCY-deep valid shift register.
  - After the last issue, goes to FLUSH.
- FLUSH: when inflight=0 and the FIFO is empty (last m handshake completed), goes to DONE.
- DRAIN stream:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - Sustained throughput is 1 word/cycle with m_ready=1; ordering is strictly address order.
  - m_data and m_valid are stable while m_valid=1 and m_ready=0.
- DONE: done=1 for one cycle, busy=0 next cycle, returns to IDLE. A cmd_start on the done cycle is ignored.
- Address arithmetic: base+i modulo 2**ADDR_WIDTH. Wrap-around is legal; count=2048 covers the whole buffer exactly once.
- FIFO full: the credit rule guarantees no overflow; a simultaneous FIFO push and pop is allowed.
- s_valid or m_ready activity outside its own mode is ignored; s_ready=0 and m_valid=0 outside FILL and DRAIN/FLUSH.

Optional Feature:
- Macro: KNN_LOCAL_BUF_PERF_CNT_EN.
- When defined:
  - Adds output stall_cycles (32 bits).
  - Counts cycles while busy=1 with either (FILL and s_valid=0) or (DRAIN/FLUSH and m_valid=1 and m_ready=0).
  - Cleared on reset and on each accepted cmd_start; saturates at 2**32-1.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Fill, then drain, base=0, count=4, s_valid=1, m_ready=1, data 0xA0..0xA3 -> writes to addresses 0..3 on 4 consecutive cycles, done pulse. Drain returns 0xA0..0xA3 in order, 4 consecutive m beats, one done pulse.
- Drain with wrap, base=2046, count=4 -> reads issued at addresses 2046, 2047, 0, 1; m_data order matches.
- Backpressure, drain count=16, m_ready toggled 1/0 every 2 cycles, READ_LATENCY=2 -> no lost or duplicated words; ce0 read issues never exceed FIFO_DEPTH outstanding; m_data held stable while stalled.
- count=0 in both modes -> ce0 never asserted; done pulses 2 cycles after cmd_start. cmd_start during busy -> ignored, no extra done.
- reset_n=0 for 1 cycle in the middle of a drain of count=8 -> all outputs 0 the next cycle, no done pulse. A new fill of count=1 afterwards completes normally.
- With KNN_LOCAL_BUF_PERF_CNT_EN, fill count=4 with s_valid low for 3 cycles -> stall_cycles=3 at done.
